serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and difference width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin one subtraction.
REQ-005 SHALL have port a  input  WIDTH  minuend, sampled only when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, sampled only when start is accepted.
REQ-007 SHALL have port bin  input  1  borrow-in, sampled only when start is accepted.
REQ-008 SHALL have port busy  output  1  high while a subtraction is in progress (RUN).
REQ-009 SHALL have port done  output  1  one-cycle pulse: diff and bout are valid.
REQ-010 SHALL have port diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
REQ-011 SHALL have port bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; acceptance latches a, b and bin into internal shift registers, clears the bit counter, and moves to RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on the operation in progress or on the latched operands.
REQ-015 SHALL process one bit per cycle in RUN, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br), with br seeded from bin.
REQ-016 SHALL stay in RUN for exactly WIDTH cycles, then enter DONE.
REQ-017 SHALL assert done for exactly the one cycle spent in DONE; done and busy SHALL never be high together.
REQ-018 SHALL assert done WIDTH+1 cycles after the cycle in which start is accepted.
REQ-019 SHALL update diff and bout only on the edge entering DONE, and hold them unchanged until the next entry into DONE or until reset.
REQ-020 SHALL go from DONE to IDLE when start is low.
REQ-021 SHALL go from DONE to RUN when start is high, so back-to-back operations run with no idle cycle between them.
REQ-022 SHALL keep the bit counter within 0..WIDTH-1 and never let it wrap during RUN.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, force state IDLE and set busy=0, done=0, diff=0, bout=0, counter=0 and internal shift registers to 0.
REQ-024 SHALL abort any RUN operation on reset, with no done pulse and no partial result ever appearing on diff.
REQ-025 SHALL ignore start in any cycle where rst_n=0.

Structure
REQ-026 SHALL place the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width expression in the shared arith package/include used by the arithmetic blocks.
REQ-027 SHALL implement the per-bit logic as one sub-module, full_subtractor (inputs x, y, bin; outputs d, bout), instantiated once.
REQ-028 SHALL infer only flip-flops and combinational logic: no latches and no multi-bit subtract operator on the datapath.

Verification (WIDTH=8)
REQ-029 SHALL cover: a=200, b=55, bin=0, start pulse -> done 9 cycles later with diff=145, bout=0, and busy high for 8 cycles.
REQ-030 SHALL cover: a=5, b=10, bin=0 -> diff=251, bout=1; then a=0, b=0, bin=1 -> diff=255, bout=1.
REQ-031 SHALL cover: a=255, b=255, bin=0 -> diff=0, bout=0; then a=255, b=0, bin=1 -> diff=254, bout=0.
REQ-032 SHALL cover: start with a=100, b=1, then start with a=0, b=1 asserted 3 cycles later (during RUN) -> only one done, diff=99, bout=0.
REQ-033 SHALL cover: start held high through DONE with new operands a=9, b=4 -> second done exactly 9 cycles after the first, diff=5; earlier diff held until then.
REQ-034 SHALL cover: rst_n low for one cycle mid-RUN -> next cycle IDLE, busy=0, diff=0, bout=0, and no done pulse follows.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the width of the bit counter.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter must hold 0..width-1; a 1-bit floor keeps tiny widths legal.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_xy;

   assign w_xy = x ^ y;
   assign d    = w_xy ^ bin;
   assign bout = (~x & y) | (~w_xy & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: latches operands on start, resolves one bit per
// cycle LSB first, and presents (a - b - bin) with borrow-out for one cycle.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic             r_br;
   logic             r_bout;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept;
   logic             w_last;
   logic             w_d;
   logic             w_bout;

   // Start is only honoured outside RUN; reset priority is handled in the flops.
   assign w_accept = start && (r_state != ST_RUN);
   assign w_last   = (r_cnt == LAST_BIT);

   full_subtractor u_full_subtractor (
      .x    (r_a[0]),
      .y    (r_b[0]),
      .bin  (r_br),
      .d    (w_d),
      .bout (w_bout)
   );

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: default assignment first so no path leaves w_next_state unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE: if (start)  w_next_state = ST_RUN;
         ST_RUN:  if (w_last) w_next_state = ST_DONE;
         ST_DONE: w_next_state = start ? ST_RUN : ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == ST_RUN);
      done = (r_state == ST_DONE);
   end

   // NOTE: the operand shift registers are reset too, so an aborted run leaves
   // no stale bits behind; they are plain flops, not a RAM, so this is free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_br   <= 1'b0;
         r_cnt  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
      end else if (w_accept) begin
         r_a   <= a;
         r_b   <= b;
         r_br  <= bin;
         r_res <= '0;
         r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_br  <= w_bout;
         r_res <= {w_d, r_res[WIDTH-1:1]};
         // Result is published only on the last bit; counter parks at WIDTH-1.
         if (w_last) begin
            r_diff <= {w_d, r_res[WIDTH-1:1]};
            r_bout <= w_bout;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8: vector table plus
// hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             bin   = 1'b0;
   logic [WIDTH-1:0] a     = '0;
   logic [WIDTH-1:0] b     = '0;
   logic             busy;
   logic             done;
   logic             bout;
   logic [WIDTH-1:0] diff;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Returns at the negedge after the accepting edge (first RUN cycle).
   task automatic launch(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
      @(negedge clk);
      a = ia; b = ib; bin = ibin; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~ia; b = ~ib; bin = ~ibin;
   endtask

   task automatic wait_done(output int lat, output int busy_cyc);
      lat = 1;
      busy_cyc = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busy_cyc++;
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int         lat;
      int         bc;
      int         ndone;
      int         first;
      logic       held_ok;
      logic [7:0] d_at;
      logic       bo_at;

      vecs[0] = '{8'd200, 8'd55,  1'b0, 8'd145, 1'b0};
      vecs[1] = '{8'd5,   8'd10,  1'b0, 8'd251, 1'b1};
      vecs[2] = '{8'd0,   8'd0,   1'b1, 8'd255, 1'b1};
      vecs[3] = '{8'd255, 8'd255, 1'b0, 8'd0,   1'b0};
      vecs[4] = '{8'd255, 8'd0,   1'b1, 8'd254, 1'b0};
      vecs[5] = '{8'd0,   8'd255, 1'b1, 8'd0,   1'b1};
      vecs[6] = '{8'd128, 8'd127, 1'b1, 8'd0,   1'b0};
      vecs[7] = '{8'd17,  8'd34,  1'b0, 8'd239, 1'b1};
      vecs[8] = '{8'd170, 8'd85,  1'b1, 8'd84,  1'b0};

      // Reset with start high: must stay idle and cleared.
      rst_n = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h11; bin = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);

      foreach (vecs[i]) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].bin);
         wait_done(lat, bc);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd9);
         check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd8);
         check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
         check($sformatf("v%0d_diff", i), 32'(diff), 32'(vecs[i].diff));
         check($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
         check($sformatf("v%0d_diff_hold", i), 32'(diff), 32'(vecs[i].diff));
      end

      // Start during RUN is ignored.
      launch(8'd100, 8'd1, 1'b0);
      repeat (2) @(negedge clk);
      a = 8'd0; b = 8'd1; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; first = 0; d_at = '0; bo_at = 1'b0;
      for (int c = 4; c <= 30; c++) begin
         if (done === 1'b1) begin
            ndone++;
            if (first == 0) begin
               first = c; d_at = diff; bo_at = bout;
            end
         end
         @(negedge clk);
      end
      check("ign_done_count", 32'(ndone), 32'd1);
      check("ign_latency", 32'(first), 32'd9);
      check("ign_diff", 32'(d_at), 32'd99);
      check("ign_bout", 32'(bo_at), 32'd0);

      // Back-to-back: start held through DONE.
      launch(8'd50, 8'd20, 1'b0);
      wait_done(lat, bc);
      check("b2b_first_latency", 32'(lat), 32'd9);
      check("b2b_first_diff", 32'(diff), 32'd30);
      a = 8'd9; b = 8'd4; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = '0; b = '0;
      check("b2b_no_idle_busy", 32'(busy), 32'd1);
      check("b2b_no_idle_done", 32'(done), 32'd0);
      held_ok = 1'b1;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         if (diff !== 8'd30) held_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      check("b2b_spacing", 32'(lat), 32'd9);
      check("b2b_diff_held", 32'(held_ok), 32'd1);
      check("b2b_second_diff", 32'(diff), 32'd5);
      check("b2b_second_bout", 32'(bout), 32'd0);
      @(negedge clk);

      // Reset mid-RUN aborts with no done and a cleared result.
      launch(8'd77, 8'd3, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_diff", 32'(diff), 32'd0);
      check("abort_bout", 32'(bout), 32'd0);
      ndone = 0; held_ok = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1) ndone++;
         if (diff !== 8'd0) held_ok = 1'b0;
         @(negedge clk);
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      check("abort_diff_stays_zero", 32'(held_ok), 32'd1);

      // Normal operation resumes after the abort.
      launch(8'd60, 8'd61, 1'b1);
      wait_done(lat, bc);
      check("recover_latency", 32'(lat), 32'd9);
      check("recover_diff", 32'(diff), 32'd254);
      check("recover_bout", 32'(bout), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_serial_subtractor
